// File: rtl/onchip_ram_pkg.sv
// Shared constants and FSM state type for the on-chip RAM burst adapter.
package onchip_ram_pkg;

    localparam int ADDR_W    = 13;
    localparam int DATA_W    = 32;
    localparam int BE_W      = DATA_W / 8;
    localparam int BURST_W   = 4;
    localparam int MAX_BURST = 8;
    localparam int RAM_DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_BURST = 2'd1,
        WR_BURST = 2'd2
    } state_e;

endpackage

// File: rtl/onchip_ram_burst_adapter.sv
// Avalon-MM bursting slave in front of a single-port on-chip RAM: replays bursts
// one beat per cycle and converts the RAM's 1-cycle read latency into readdatavalid.
module onchip_ram_burst_adapter #(
    parameter int ADDR_W    = onchip_ram_pkg::ADDR_W,
    parameter int DATA_W    = onchip_ram_pkg::DATA_W,
    parameter int BE_W      = onchip_ram_pkg::BE_W,
    parameter int BURST_W   = onchip_ram_pkg::BURST_W,
    parameter int MAX_BURST = onchip_ram_pkg::MAX_BURST
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [ADDR_W-1:0]  s_address,
    input  logic [BURST_W-1:0] s_burstcount,
    input  logic               s_read,
    input  logic               s_write,
    input  logic [DATA_W-1:0]  s_writedata,
    input  logic [BE_W-1:0]    s_byteenable,
    output logic               s_waitrequest,
    output logic [DATA_W-1:0]  s_readdata,
    output logic               s_readdatavalid,
    output logic [ADDR_W-1:0]  m_address,
    output logic [BE_W-1:0]    m_byteenable,
    output logic               m_chipselect,
    output logic               m_write,
    output logic [DATA_W-1:0]  m_writedata,
    output logic               m_clken,
    input  logic [DATA_W-1:0]  m_readdata
);
    import onchip_ram_pkg::*;

    localparam logic [BURST_W-1:0] MAX_BC = BURST_W'(MAX_BURST);
    localparam logic [BURST_W-1:0] ONE_BC = BURST_W'(1);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [BURST_W-1:0]  rem_q, rem_d;
    logic [BURST_W-1:0]  bc_eff;
    logic                bubble_q, bubble_d;
    logic                accept, rd_issue;
    logic                issue_q, rdv_q;
    logic [DATA_W-1:0]   rdata_q;

    always_comb begin
        bc_eff = s_burstcount;
        if (s_burstcount == '0)
            bc_eff = ONE_BC;
        else if (s_burstcount > MAX_BC)
            bc_eff = MAX_BC;
    end

    assign accept   = !reset && (state_q == IDLE) && !bubble_q;
    assign rd_issue = !reset && (state_q == RD_BURST);
    // Holds off the next command for one cycle after the final read issue.
    assign bubble_d = rd_issue && (rem_q == ONE_BC);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            rem_q    <= '0;
            bubble_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            rem_q    <= rem_d;
            bubble_q <= bubble_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        case (state_q)
            IDLE: begin
                if (accept && s_write) begin
                    if (bc_eff > ONE_BC) begin
                        state_d = WR_BURST;
                        addr_d  = s_address + ADDR_W'(1);
                        rem_d   = bc_eff - ONE_BC;
                    end
                end else if (accept && s_read) begin
                    state_d = RD_BURST;
                    addr_d  = s_address;
                    rem_d   = bc_eff;
                end
            end
            WR_BURST: begin
                if (s_write) begin
                    addr_d = addr_q + ADDR_W'(1);
                    rem_d  = rem_q - ONE_BC;
                    if (rem_q == ONE_BC)
                        state_d = IDLE;
                end
            end
            RD_BURST: begin
                addr_d = addr_q + ADDR_W'(1);
                rem_d  = rem_q - ONE_BC;
                if (rem_q == ONE_BC)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        s_waitrequest = 1'b1;
        m_chipselect  = 1'b0;
        m_write       = 1'b0;
        m_address     = addr_q;
        m_byteenable  = '1;
        m_writedata   = s_writedata;
        if (reset) begin
            m_address = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    s_waitrequest = bubble_q;
                    // Beat 0 of a write goes straight through in the accept cycle.
                    if (accept && s_write) begin
                        m_chipselect = 1'b1;
                        m_write      = 1'b1;
                        m_address    = s_address;
                        m_byteenable = s_byteenable;
                    end
                end
                WR_BURST: begin
                    s_waitrequest = 1'b0;
                    if (s_write) begin
                        m_chipselect = 1'b1;
                        m_write      = 1'b1;
                        m_byteenable = s_byteenable;
                    end
                end
                RD_BURST: m_chipselect = 1'b1;
                default: ;
            endcase
        end
    end

    assign m_clken = 1'b1;

    // Issue in N, RAM q in N+1, registered beat visible in N+2.
    always_ff @(posedge clk) begin
        if (reset) begin
            issue_q <= 1'b0;
            rdv_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            issue_q <= rd_issue;
            rdv_q   <= issue_q;
            if (issue_q)
                rdata_q <= m_readdata;
        end
    end

    assign s_readdata      = rdata_q;
    assign s_readdatavalid = rdv_q;

    a_rd_wr_exclusive: assert property (@(posedge clk) disable iff (reset)
        !(accept && s_read && s_write));

endmodule

// File: tb/tb_onchip_ram_burst_adapter.sv
// Randomised scoreboard bench for onchip_ram_burst_adapter with a behavioural RAM.
module tb_onchip_ram_burst_adapter;
    import onchip_ram_pkg::*;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic [ADDR_W-1:0]  s_address = '0;
    logic [BURST_W-1:0] s_burstcount = '0;
    logic               s_read = 1'b0;
    logic               s_write = 1'b0;
    logic [DATA_W-1:0]  s_writedata = '0;
    logic [BE_W-1:0]    s_byteenable = '0;
    logic               s_waitrequest;
    logic [DATA_W-1:0]  s_readdata;
    logic               s_readdatavalid;
    logic [ADDR_W-1:0]  m_address;
    logic [BE_W-1:0]    m_byteenable;
    logic               m_chipselect;
    logic               m_write;
    logic [DATA_W-1:0]  m_writedata;
    logic               m_clken;
    logic [DATA_W-1:0]  m_readdata = '0;

    onchip_ram_burst_adapter dut (
        .clk(clk), .reset(reset),
        .s_address(s_address), .s_burstcount(s_burstcount),
        .s_read(s_read), .s_write(s_write),
        .s_writedata(s_writedata), .s_byteenable(s_byteenable),
        .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
        .s_readdatavalid(s_readdatavalid),
        .m_address(m_address), .m_byteenable(m_byteenable),
        .m_chipselect(m_chipselect), .m_write(m_write),
        .m_writedata(m_writedata), .m_clken(m_clken),
        .m_readdata(m_readdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM under the adapter: registered q, byte-lane writes.
    logic [DATA_W-1:0] ram [RAM_DEPTH];
    always @(posedge clk) begin
        if (m_clken && m_chipselect) begin
            if (m_write) begin
                for (int b = 0; b < BE_W; b++)
                    if (m_byteenable[b]) ram[m_address][8*b +: 8] <= m_writedata[8*b +: 8];
            end else begin
                m_readdata <= ram[m_address];
            end
        end
    end

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [BE_W-1:0]   be;
    } wr_t;

    logic [DATA_W-1:0] ref_mem [RAM_DEPTH];
    wr_t               exp_wr[$];
    logic [ADDR_W-1:0] exp_rd_addr[$];
    logic [DATA_W-1:0] exp_rd_data[$];
    int                exp_rd_cyc[$];

    int nchk = 0, nerr = 0;
    int wr_count = 0, n_issue = 0, rdv_count = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int eff(input int bc);
        if (bc == 0) return 1;
        if (bc > MAX_BURST) return MAX_BURST;
        return bc;
    endfunction

    // Monitor: pops expectations whenever the DUT touches the RAM or returns data.
    wr_t mw;
    int  icyc;
    always @(negedge clk) begin
        if (!reset) begin
            if (m_chipselect && m_write) begin
                wr_count++;
                check("wr_expected", 64'(exp_wr.size() != 0), 1);
                if (exp_wr.size() != 0) begin
                    mw = exp_wr.pop_front();
                    check("wr_beat", {m_address, m_writedata, m_byteenable}, mw);
                end
            end
            if (m_chipselect && !m_write) begin
                n_issue++;
                check("rd_issue_expected", 64'(exp_rd_addr.size() != 0), 1);
                if (exp_rd_addr.size() != 0) check("rd_issue_addr", m_address, exp_rd_addr.pop_front());
                exp_rd_cyc.push_back(cyc);
            end
            if (s_readdatavalid) begin
                rdv_count++;
                check("rdv_expected", 64'(exp_rd_data.size() != 0), 1);
                if (exp_rd_data.size() != 0) check("rd_data", s_readdata, exp_rd_data.pop_front());
                if (exp_rd_cyc.size() != 0) begin
                    icyc = exp_rd_cyc.pop_front();
                    check("rd_latency", cyc, icyc + 2);
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk); #1;
    endtask

    // Waits (bounded) for the command currently driven to be accepted; call at posedge+1.
    task automatic wait_accept(input string nm, output bit ok);
        int t;
        t = 0;
        #1;
        while (s_waitrequest && t < 50) begin
            tick; #1; t++;
        end
        ok = (t < 50);
        if (!ok) check(nm, 64'(t), 0);
    endtask

    task automatic do_write(input logic [ADDR_W-1:0] a, input int bc, input logic [DATA_W-1:0] d0,
                            input bit rnd, input int stall_beat, input int stall_len);
        int n;
        bit ok;
        logic [DATA_W-1:0] d;
        logic [BE_W-1:0]   be;
        logic [ADDR_W-1:0] wa;
        n = eff(bc);
        for (int i = 0; i < n; i++) begin
            d  = rnd ? DATA_W'($urandom) : d0 + DATA_W'(i);
            be = rnd ? BE_W'($urandom) : '1;
            wa = a + ADDR_W'(i);
            if (i == stall_beat) begin
                s_write = 1'b0;
                repeat (stall_len) tick;
            end
            s_write = 1'b1; s_address = a; s_burstcount = BURST_W'(bc);
            s_writedata = d; s_byteenable = be;
            if (i == 0) begin
                wait_accept("wr_accept_timeout", ok);
                if (!ok) begin s_write = 1'b0; return; end
            end else begin
                #1;
                check("wr_burst_waitreq", s_waitrequest, 0);
            end
            exp_wr.push_back('{addr: wa, data: d, be: be});
            for (int b = 0; b < BE_W; b++)
                if (be[b]) ref_mem[wa][8*b +: 8] = d[8*b +: 8];
            tick;
        end
        s_write = 1'b0;
    endtask

    task automatic do_read(input logic [ADDR_W-1:0] a, input int bc);
        bit ok;
        logic [ADDR_W-1:0] ra;
        s_read = 1'b1; s_address = a; s_burstcount = BURST_W'(bc);
        wait_accept("rd_accept_timeout", ok);
        if (ok) begin
            for (int i = 0; i < eff(bc); i++) begin
                ra = a + ADDR_W'(i);
                exp_rd_addr.push_back(ra);
                exp_rd_data.push_back(ref_mem[ra]);
            end
        end
        tick;
        s_read = 1'b0;
    endtask

    task automatic drain;
        int t;
        t = 0;
        while ((exp_rd_data.size() != 0 || exp_rd_addr.size() != 0) && t < 100) begin
            tick; t++;
        end
        check("drain_pending", 64'(exp_rd_data.size() + exp_rd_addr.size()), 0);
        tick; tick;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_waitreq"}, s_waitrequest, 1);
        check({tag, "_cs"}, m_chipselect, 0);
        check({tag, "_mwrite"}, m_write, 0);
        check({tag, "_maddr"}, m_address, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, t, mism;
        logic [ADDR_W-1:0] ra;
        for (int i = 0; i < RAM_DEPTH; i++) begin ram[i] = '0; ref_mem[i] = '0; end

        // Reset state
        tick; tick;
        @(negedge clk);
        check_reset_outputs("rst");
        check("rst_rdv", s_readdatavalid, 0);
        check("rst_rdata", s_readdata, 0);
        @(posedge clk); #1 reset = 1'b0;
        tick;

        // 1: write burst, 2: read it back
        do_write(13'h010, 4, 32'hA0, 0, -1, 0);
        for (int i = 0; i < 4; i++) begin
            ra = 13'h010 + ADDR_W'(i);
            check("t1_ram", ram[ra], 32'hA0 + i);
        end
        do_read(13'h010, 4);
        drain;

        // 3: wrap at the top of memory
        do_write(13'h1FFF, 3, 32'h55500000, 0, -1, 0);
        check("t3_ram_1fff", ram[13'h1FFF], 32'h55500000);
        check("t3_ram_0000", ram[13'h0000], 32'h55500001);
        check("t3_ram_0001", ram[13'h0001], 32'h55500002);
        do_read(13'h1FFF, 3);
        drain;

        // 4: master stall mid-burst
        base = wr_count;
        do_write(13'h100, 4, 32'hC0, 0, 2, 3);
        tick;
        check("t4_wr_count", wr_count - base, 4);
        do_read(13'h100, 4);
        drain;

        // 5: reset during beat 2 of an 8-beat read
        do_read(13'h200, 8);
        base = n_issue; t = 0;
        while (n_issue < base + 2 && t < 50) begin @(negedge clk); #1; t++; end
        check("t5_issue_wait", 64'(t >= 50), 0);
        @(posedge clk); #1 reset = 1'b1;
        @(negedge clk);
        check_reset_outputs("t5_rst");
        #1;
        exp_rd_addr.delete(); exp_rd_data.delete(); exp_rd_cyc.delete();
        base = n_issue; t = wr_count;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check("t5_rdv_after", s_readdatavalid, 0);
        check("t5_rdata_after", s_readdata, 0);
        repeat (5) tick;
        check("t5_no_issue", n_issue - base, 0);
        check("t5_no_write", wr_count - t, 0);
        do_write(13'h300, 2, 32'hD0, 0, -1, 0);
        do_read(13'h300, 2);
        drain;

        // 6: burstcount 0 and over-range clamp
        base = rdv_count;
        do_read(13'h010, 0);
        drain;
        check("t6_bc0_beats", rdv_count - base, 1);
        base = rdv_count;
        do_read(13'h400, 15);
        drain;
        check("t6_bc15_beats", rdv_count - base, 8);

        // Randomised traffic
        for (int k = 0; k < 25; k++) begin
            ra = ADDR_W'($urandom);
            do_write(ra, int'($urandom_range(0, 15)), '0, 1,
                     ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : -1,
                     int'($urandom_range(1, 3)));
            if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) tick;
            do_read(ra, int'($urandom_range(0, 15)));
            if ($urandom_range(0, 2) == 0) drain;
        end
        drain;

        check("final_wr_pending", 64'(exp_wr.size()), 0);
        mism = 0;
        for (int i = 0; i < RAM_DEPTH; i++) if (ram[i] !== ref_mem[i]) mism++;
        check("mem_image", 64'(mism), 0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
